fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 32 +++
 rtl/fetch_buffer.sv | 67 ++++++
 rtl/fetch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// No logic; pure declarations consumed by fetch_unit and fetch_buffer.
// No flow control of its own.
package fetch_unit_pkg;

   // First fetch address after reset unless the instance overrides it
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

   // Fetch buffer geometry: two {pc,inst} entries of 64 bits
   localparam int unsigned FB_DEPTH = 2;
   localparam int unsigned FB_WIDTH = 64;
   localparam int unsigned FB_CW    = $clog2(FB_DEPTH + 1);

   // IDLE: no request; WAIT: request outstanding, keep result;
   // KILL: request outstanding, result belongs to a squashed path
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_KILL = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // Instruction addresses are word aligned; low two bits are dropped
   function automatic logic [31:0] align_word(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order FIFO holding fetched {pc,inst} entries for decode.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: push is dropped when full without a pop; flush beats push/pop.
module fetch_buffer #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   input  logic             flush,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q;
   logic [PW-1:0]    wr_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop  = pop && (count_q != '0);
   assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

   // Storage, pointers and occupancy; flush empties without writing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word requests to the I-cache and queues results for decode.
// Latency: cache hit requested at t completes at t+1, entry at decode at t+2.
// Backpressure: a new request starts only with a free buffer slot; redirects squash.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] ic_req_addr,
   output logic        ic_req_valid,
   input  logic [31:0] ic_inst,
   input  logic        ic_ready,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   input  logic        id_ready
);

   localparam logic [FB_CW-1:0] FB_FULL = FB_CW'(FB_DEPTH);

   fetch_state_t       state_q;
   fetch_state_t       state_d;
   logic [31:0]        pc_q;
   logic [31:0]        pc_d;
   logic [31:0]        tgt_q;
   logic [31:0]        tgt_d;
   logic [31:0]        redirect_addr;
   logic [FB_CW-1:0]   fb_count;
   logic [FB_CW-1:0]   count_next;
   logic               push;
   logic               pop;
   logic               flush;
   fetch_entry_t       push_entry;
   fetch_entry_t       head_entry;

   assign redirect_addr = align_word(redirect_pc);

   // Only a live (non-squashed) response is kept, and never alongside a redirect
   assign push  = (state_q == ST_WAIT) && ic_ready && !redirect_valid;
   assign pop   = id_valid && id_ready;
   assign flush = redirect_valid;

   assign push_entry.pc   = pc_q;
   assign push_entry.inst = ic_inst;

   fetch_buffer #(
      .DEPTH (FB_DEPTH),
      .WIDTH (FB_WIDTH)
   ) u_fetch_buffer (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (push_entry),
      .pop      (pop),
      .flush    (flush),
      .count    (fb_count),
      .head     (head_entry)
   );

   // Buffer occupancy as it will be after this edge, used to decide whether to refetch
   always_comb begin
      count_next = fb_count;
      if (flush) begin
         count_next = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_next = fb_count + 1'b1;
            2'b01:   count_next = fb_count - 1'b1;
            default: count_next = fb_count;
         endcase
      end
   end

   // State, fetch address and pending redirect target registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_WAIT;
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
      end
   end

   // Next state; pc only moves when no request is live, so the cache sees a stable address
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      case (state_q)
         ST_IDLE: begin
            if (redirect_valid) begin
               pc_d    = redirect_addr;
               state_d = ST_WAIT;
            end else if (fb_count < FB_FULL) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT, ST_KILL: begin
            if (redirect_valid && !ic_ready) begin
               // Cannot abandon the live request; remember where to go once it lands
               tgt_d   = redirect_addr;
               state_d = ST_KILL;
            end else if (ic_ready) begin
               if (redirect_valid) begin
                  pc_d = redirect_addr;
               end else if (state_q == ST_WAIT) begin
                  pc_d = pc_q + 32'd4;
               end else begin
                  pc_d = tgt_q;
               end
               state_d = (count_next < FB_FULL) ? ST_WAIT : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_WAIT;
         end
      endcase
   end

   // Cache request and decode-facing outputs
   always_comb begin
      ic_req_valid = (state_q != ST_IDLE);
      ic_req_addr  = pc_q;
      id_valid     = (fb_count != '0);
      id_pc        = head_entry.pc;
      id_inst      = head_entry.inst;
   end

endmodule
